// File: rtl/fir_pkg.sv
// Shared defaults and player state encoding for the FIR stimulus/capture engine.
package fir_pkg;

  localparam int N2_DEFAULT = 16;
  localparam int N3_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PLAY  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } player_state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// Register-array memory with one write port and one registered, gated read port.
module fir_sample_ram
  import fir_pkg::*;
#(
  parameter int WIDTH  = N2_DEFAULT,
  parameter int DEPTH  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array itself is never reset; only the read register is, so the storage maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wr_addr} < DEPTH_C)) mem[wr_addr] <= wr_data;
  end

  // A disabled or out-of-range read returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!rd_en || ({1'b0, rd_addr} >= DEPTH_C)) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fir_stream_player.sv
// Plays preloaded samples into a FIR filter and captures its outputs into a result memory.
// Define FIR_PLAYER_CHECKSUM_EN to add a running CHECKSUM of captured results.
module fir_stream_player
  import fir_pkg::*;
#(
  parameter int N2         = N2_DEFAULT,
  parameter int N3         = N3_DEFAULT,
  parameter int DEPTH      = 100,
  parameter int ADDR_W     = 7,
  parameter int FIR_LAT    = 1,
  parameter int CLR_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_WE,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [N2-1:0]     LOAD_DATA,
  input  logic              START,
  input  logic [ADDR_W:0]   NUM_SAMPLES,
  output logic              FIR_RST,
  output logic              FIR_ENABLE,
  output logic [N2-1:0]     FIR_DATA_IN,
  input  logic [N3-1:0]     FIR_DATA_OUT,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [N3-1:0]     RD_DATA,
  output logic              BUSY,
  output logic              DONE,
`ifdef FIR_PLAYER_CHECKSUM_EN
  output logic [N3-1:0]     CHECKSUM,
`endif
  output logic [ADDR_W:0]   CAPTURE_COUNT
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  player_state_t      state;
  logic [ADDR_W:0]    n_run;
  logic [ADDR_W:0]    n_req;
  logic [ADDR_W:0]    idx;
  logic [CLR_W-1:0]   clr_cnt;
  logic               drive_valid;
  logic [FIR_LAT-1:0] vpipe;
  logic               idle_like;
  logic               fetch;
  logic               capture;
  logic               last_capture;

  // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
  always_comb begin
    idle_like    = (state == S_IDLE) || (state == S_DONE);
    n_req        = (NUM_SAMPLES > DEPTH_C) ? DEPTH_C : NUM_SAMPLES;
    fetch        = ((state == S_CLEAR) && (clr_cnt == CLR_LAST)) ||
                   ((state == S_PLAY) && (idx != n_run));
    capture      = vpipe[FIR_LAT-1] && ((state == S_PLAY) || (state == S_DRAIN));
    last_capture = capture && ((CAPTURE_COUNT + (ADDR_W + 1)'(1)) == n_run);
  end

  // The sample memory's read register is FIR_DATA_IN itself; fetch is issued one cycle ahead.
  fir_sample_ram #(.WIDTH(N2), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_samples (
    .clk     (CLK),
    .rst_n   (RST),
    .we      (LOAD_WE && idle_like),
    .wr_addr (LOAD_ADDR),
    .wr_data (LOAD_DATA),
    .rd_en   (fetch),
    .rd_addr (idx[ADDR_W-1:0]),
    .rd_data (FIR_DATA_IN)
  );

  fir_sample_ram #(.WIDTH(N3), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_results (
    .clk     (CLK),
    .rst_n   (RST),
    .we      (capture),
    .wr_addr (CAPTURE_COUNT[ADDR_W-1:0]),
    .wr_data (FIR_DATA_OUT),
    .rd_en   (1'b1),
    .rd_addr (RD_ADDR),
    .rd_data (RD_DATA)
  );

  // drive_valid marks a real sample on FIR_DATA_IN; the pipe delays it to the filter's output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drive_valid <= 1'b0;
      vpipe       <= '0;
    end else begin
      drive_valid <= fetch;
      vpipe[0]    <= drive_valid;
      for (int i = 1; i < FIR_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      FIR_RST       <= 1'b0;
      FIR_ENABLE    <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      CAPTURE_COUNT <= '0;
      n_run         <= '0;
      idx           <= '0;
      clr_cnt       <= '0;
`ifdef FIR_PLAYER_CHECKSUM_EN
      CHECKSUM      <= '0;
`endif
    end else begin
      if (fetch) idx <= idx + (ADDR_W + 1)'(1);
      if (capture) begin
        CAPTURE_COUNT <= CAPTURE_COUNT + (ADDR_W + 1)'(1);
`ifdef FIR_PLAYER_CHECKSUM_EN
        CHECKSUM      <= CHECKSUM + FIR_DATA_OUT;
`endif
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            n_run         <= n_req;
            DONE          <= 1'b0;
            CAPTURE_COUNT <= '0;
            idx           <= '0;
            clr_cnt       <= '0;
`ifdef FIR_PLAYER_CHECKSUM_EN
            CHECKSUM      <= '0;
`endif
            if (n_req == '0) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else begin
              state   <= S_CLEAR;
              FIR_RST <= 1'b1;
              BUSY    <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            FIR_RST    <= 1'b0;
            FIR_ENABLE <= 1'b1;
            state      <= S_PLAY;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        S_PLAY: begin
          if (!fetch) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_capture) begin
            FIR_ENABLE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            state      <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_player.sv
// Directed bench: two players (FIR_LAT=1 and FIR_LAT=3) share host stimulus, each with a 3*x filter model.
module tb_fir_stream_player;

  logic        clk;
  logic        rst_n;
  logic        load_we;
  logic [6:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic [7:0]  num_samples;
  logic [6:0]  rd_addr;

  logic        fir_rst1, fir_en1, busy1, done1;
  logic [15:0] fir_din1;
  logic [31:0] fir_dout1, rd_data1;
  logic [7:0]  cnt1;
  logic        fir_rst3, fir_en3, busy3, done3;
  logic [15:0] fir_din3;
  logic [31:0] fir_dout3, rd_data3;
  logic [7:0]  cnt3;
`ifdef FIR_PLAYER_CHECKSUM_EN
  logic [31:0] checksum1, checksum3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fir_stream_player #(.FIR_LAT(1)) u_dut (
    .CLK(clk), .RST(rst_n), .LOAD_WE(load_we), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .START(start), .NUM_SAMPLES(num_samples), .FIR_RST(fir_rst1), .FIR_ENABLE(fir_en1),
    .FIR_DATA_IN(fir_din1), .FIR_DATA_OUT(fir_dout1), .RD_ADDR(rd_addr), .RD_DATA(rd_data1),
    .BUSY(busy1), .DONE(done1),
`ifdef FIR_PLAYER_CHECKSUM_EN
    .CHECKSUM(checksum1),
`endif
    .CAPTURE_COUNT(cnt1)
  );

  fir_stream_player #(.FIR_LAT(3)) u_dut_lat3 (
    .CLK(clk), .RST(rst_n), .LOAD_WE(load_we), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data),
    .START(start), .NUM_SAMPLES(num_samples), .FIR_RST(fir_rst3), .FIR_ENABLE(fir_en3),
    .FIR_DATA_IN(fir_din3), .FIR_DATA_OUT(fir_dout3), .RD_ADDR(rd_addr), .RD_DATA(rd_data3),
    .BUSY(busy3), .DONE(done3),
`ifdef FIR_PLAYER_CHECKSUM_EN
    .CHECKSUM(checksum3),
`endif
    .CAPTURE_COUNT(cnt3)
  );

  // Filter models: out = 3*in, registered through 1 or 3 stages.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    if (fir_rst1) p1 <= '0;
    else if (fir_en1) p1 <= 32'(fir_din1) * 32'd3;
  end
  always @(posedge clk) begin
    if (fir_rst3) begin
      p3[0] <= '0; p3[1] <= '0; p3[2] <= '0;
    end else if (fir_en3) begin
      p3[0] <= 32'(fir_din3) * 32'd3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign fir_dout1 = p1;
  assign fir_dout3 = p3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [6:0] a, input logic [15:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic read_res(input logic [6:0] a, output logic [31:0] d1, output logic [31:0] d3);
    rd_addr = a;
    @(posedge clk); #1;
    d1 = rd_data1;
    d3 = rd_data3;
  endtask

  // Pulses START, optionally injects START+LOAD_WE at edge-count inject_k, and times DONE on both players.
  task automatic run(input string tag, input int num, input int inject_k,
                     input int exp_lat1, input int exp_lat3, input int exp_cnt);
    int lat1, lat3, rst_hi, bound;
    logic busy_seen, en_seen;
    logic [15:0] din2;
    lat1 = -1; lat3 = -1; rst_hi = 0; busy_seen = 1'b0; en_seen = 1'b0; din2 = '0;
    bound = num + 40;
    start = 1'b1; num_samples = 8'(num);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= bound; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (fir_rst1) rst_hi++;
      busy_seen = busy_seen | busy1;
      en_seen   = en_seen | fir_en1;
      if (k == 2) din2 = fir_din1;
      if (k == inject_k) begin
        start = 1'b1; num_samples = 8'd50;
        load_we = 1'b1; load_addr = 7'd3; load_data = 16'h7FFF;
      end else if (k == inject_k + 1) begin
        start = 1'b0; load_we = 1'b0;
      end
      if (done1 && lat1 < 0) lat1 = k;
      if (done3 && lat3 < 0) lat3 = k;
      if (lat1 >= 0 && lat3 >= 0 && k > inject_k + 1) break;
    end
    check({tag, " done latency lat1"}, lat1, exp_lat1);
    check({tag, " done latency lat3"}, lat3, exp_lat3);
    check({tag, " capture count lat1"}, 32'(cnt1), exp_cnt);
    check({tag, " capture count lat3"}, 32'(cnt3), exp_cnt);
    check({tag, " fir_enable low at end"}, 32'(fir_en1), 0);
    if (num > 0) begin
      check({tag, " fir_rst cycles"}, rst_hi, 2);
      check({tag, " first sample driven"}, 32'(din2), 1);
    end else begin
      check({tag, " fir_rst cycles"}, rst_hi, 0);
      check({tag, " busy seen"}, 32'(busy_seen), 0);
      check({tag, " enable seen"}, 32'(en_seen), 0);
    end
  endtask

  initial begin
    vec_t vecs [8];
    logic [31:0] d1, d3;

    vecs[0] = '{7'd0,   32'd3};
    vecs[1] = '{7'd3,   32'd12};
    vecs[2] = '{7'd9,   32'd30};
    vecs[3] = '{7'd50,  32'd153};
    vecs[4] = '{7'd98,  32'd297};
    vecs[5] = '{7'd99,  32'd300};
    vecs[6] = '{7'd100, 32'd0};
    vecs[7] = '{7'd127, 32'd0};

    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; num_samples = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy1), 0);
    check("reset done", 32'(done1), 0);
    check("reset capture count", 32'(cnt1), 0);
    check("reset fir_enable", 32'(fir_en1), 0);
    check("reset fir_data_in", 32'(fir_din1), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run: samples 1..10, expect results 3..30.
    for (int i = 0; i < 10; i++) load(7'(i), 16'(i + 1));
    run("basic", 10, -1, 13, 15, 10);
    for (int i = 0; i < 10; i++) begin
      read_res(7'(i), d1, d3);
      check($sformatf("basic result[%0d] lat1", i), d1, 32'(3 * (i + 1)));
      check($sformatf("basic result[%0d] lat3", i), d3, 32'(3 * (i + 1)));
    end
`ifdef FIR_PLAYER_CHECKSUM_EN
    check("checksum lat1", checksum1, 32'd165);
    check("checksum lat3", checksum3, 32'd165);
`endif

    // Zero-length run goes straight to DONE with the filter untouched.
    run("zero", 0, -1, 0, 0, 0);

    // START and a sample write arriving mid-PLAY are both ignored.
    run("inject", 10, 3, 13, 15, 10);
    read_res(7'd3, d1, d3);
    check("inject result[3] lat1", d1, 32'd12);
    check("inject result[3] lat3", d3, 32'd12);

    // Oversized request is clamped to the memory depth.
    for (int i = 10; i < 100; i++) load(7'(i), 16'(i + 1));
    run("clamp", 120, -1, 103, 105, 100);
    foreach (vecs[i]) begin
      read_res(vecs[i].addr, d1, d3);
      check($sformatf("clamp table addr %0d lat1", vecs[i].addr), d1, vecs[i].exp);
      check($sformatf("clamp table addr %0d lat3", vecs[i].addr), d3, vecs[i].exp);
    end

    // Reset mid-PLAY aborts; a later run restarts cleanly.
    rd_addr = 7'd9;
    start = 1'b1; num_samples = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort precondition busy", 32'(busy1), 1);
    check("abort precondition captures", 32'(cnt1), 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy1), 0);
    check("abort fir_enable", 32'(fir_en1), 0);
    check("abort fir_rst", 32'(fir_rst1), 0);
    check("abort fir_data_in", 32'(fir_din1), 0);
    check("abort capture count", 32'(cnt1), 0);
    check("abort rd_data", rd_data1, 0);
    check("abort done", 32'(done1), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("rerun", 10, -1, 13, 15, 10);
    read_res(7'd4, d1, d3);
    check("rerun result[4]", d1, 32'd15);
    read_res(7'd9, d1, d3);
    check("rerun result[9]", d1, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_stream_player.md
Name: fir_stream_player

Overview:
- Synthesizable stimulus/capture engine for the FIR filter.
- Host preloads input samples into an on-chip sample memory, then pulses START.
- The block resets and enables the filter, streams one sample per clock into it, and captures each filtered output into a result memory.
- Host reads results back through a registered read port.
- Sits between the host/register interface and the fir_filter input_data/output_data/ENABLE/RST pins.

Parameters:
N2, 16, input sample word width
N3, 32, filter output word width
DEPTH, 100, samples per run (sample and result memory depth)
ADDR_W, 7, address width, ceil(log2(DEPTH))
FIR_LAT, 1, cycles from sample driven to corresponding filter output valid (>=1)
CLR_CYCLES, 2, cycles FIR_RST held high before streaming (>=1)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
LOAD_WE  in  1  sample memory write strobe
LOAD_ADDR  in  ADDR_W  sample memory write address
LOAD_DATA  in  N2  sample memory write data
START  in  1  run request, single-cycle pulse
NUM_SAMPLES  in  ADDR_W+1  sample count, latched at START
FIR_RST  out  1  active-high reset to filter
FIR_ENABLE  out  1  filter enable
FIR_DATA_IN  out  N2  sample to filter
FIR_DATA_OUT  in  N3  filter output
RD_ADDR  in  ADDR_W  result memory read address
RD_DATA  out  N3  result word, 1-cycle registered read
BUSY  out  1  run in progress
DONE  out  1  sticky completion flag
CAPTURE_COUNT  out  ADDR_W+1  results captured this run

Behaviour:
- Reset (RST=0, async): state IDLE; FIR_RST=0, FIR_ENABLE=0, FIR_DATA_IN=0, RD_DATA=0, BUSY=0, DONE=0, CAPTURE_COUNT=0, indices and valid pipe cleared. Memory contents are not reset.
- Reset mid-run aborts immediately; no further captures.
- States: IDLE -> CLEAR -> PLAY -> DRAIN -> DONE -> (START) CLEAR.
- IDLE/DONE:
  - LOAD_WE writes sample memory; LOAD_ADDR>=DEPTH is ignored.
  - START latches n=min(NUM_SAMPLES,DEPTH), clears DONE and CAPTURE_COUNT.
  - If n=0, go straight to DONE (DONE=1 next cycle, FIR untouched); else go to CLEAR.
- CLEAR: FIR_RST=1, FIR_ENABLE=0 for exactly CLR_CYCLES cycles, then PLAY.
- PLAY:
  - FIR_RST=0, FIR_ENABLE=1.
  - Each cycle, FIR_DATA_IN=sample[idx] (registered output) and idx increments.
  - A valid bit enters a FIR_LAT-deep shift pipe alongside each sample.
  - After sample n-1 is driven, go to DRAIN.
- DRAIN: FIR_ENABLE stays 1, FIR_DATA_IN=0, zeros enter the valid pipe until CAPTURE_COUNT==n; then FIR_ENABLE=0 and go to DONE.
- Capture: when the valid pipe output is 1, FIR_DATA_OUT is written to result[CAPTURE_COUNT] and CAPTURE_COUNT increments. Captures occur in PLAY and DRAIN.
- Result k corresponds to sample k, taken FIR_LAT cycles after sample k is driven.
- BUSY=1 in CLEAR/PLAY/DRAIN. DONE=1 in DONE state only; it persists until the next START or reset.
- START while BUSY is ignored. LOAD_WE while BUSY is ignored (sample memory is frozen during a run).
- START and LOAD_WE in the same idle cycle: the write completes first, so the run uses the new data.
- RD_ADDR is read every cycle in any state. RD_ADDR>=DEPTH returns 0. Reading an address being written the same cycle returns the old value.
- Total run length: CLR_CYCLES + n + FIR_LAT cycles from START to DONE.

Optional Feature:
- FIR_PLAYER_CHECKSUM_EN defined: adds output CHECKSUM [N3] = modulo-2^N3 sum of all results captured this run. Cleared at START and reset, updated in the same cycle as each capture.
- Undefined: no CHECKSUM port, no adder logic.

Decomposition:
- Package fir_pkg: N2/N3 defaults and the player state encoding (IDLE=0, CLEAR=1, PLAY=2, DRAIN=3, DONE=4; 3-bit).
- One sub-module, fir_sample_ram: a parameterized WIDTH/DEPTH register-array with one write port and one registered read port. It is instantiated twice (samples N2, results N3).

Test Plan:
- Load samples 0..9 = 1,2,...,10; filter model out = 3*in, FIR_LAT=1; NUM_SAMPLES=10, START -> FIR_RST high 2 cycles, results[0..9] = 3..30, DONE after 2+10+1=13 cycles, CAPTURE_COUNT=10.
- NUM_SAMPLES=0, START -> DONE=1 next cycle, BUSY never 1, FIR_ENABLE stays 0.
- NUM_SAMPLES=120 -> clamped to 100; CAPTURE_COUNT ends at 100, last result written at address 99.
- START and LOAD_WE addr 3 value 0x7FFF pulsed mid-PLAY -> both ignored; sample 3 unchanged, run count unchanged.
- Deassert RST during PLAY after 5 samples -> all outputs 0 same cycle, state IDLE; a new START runs cleanly with CAPTURE_COUNT restarting at 0.
- With FIR_PLAYER_CHECKSUM_EN and the first scenario's data -> CHECKSUM = 165; rerun with FIR_LAT=3 -> results unchanged, DONE after 15 cycles.
